// File: rtl/decode_pkg.sv
// decode_pkg: shared op/immediate enums, opcode constants and the stored decode bundle
package decode_pkg;
    typedef enum logic [5:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_ECALL, OP_EBREAK,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_ILLEGAL = 6'h3F
    } op_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_NONE} imm_sel_e;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // imm is kept at 32 bits; the stage sign-extends it to XLEN
    typedef struct packed {
        op_e         op;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_en;
        logic        rs2_en;
        logic        rd_en;
        logic        illegal;
    } decoded_s;
endpackage

// File: rtl/decode_comb.sv
// decode_comb: combinational RV32I decoder; DECODE_RV32M_EN enables the M-extension ops
module decode_comb
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_s    dec
);
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    op_e op;
    imm_sel_e sel;
    logic r1, r2, wr;
    logic [31:0] imm;
    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];
    always_comb begin
        op = OP_ILLEGAL; sel = IMM_NONE; r1 = 1'b0; r2 = 1'b0; wr = 1'b0;
        case (opc)
            OPC_LUI:   begin op = OP_LUI;   sel = IMM_U; wr = 1'b1; end
            OPC_AUIPC: begin op = OP_AUIPC; sel = IMM_U; wr = 1'b1; end
            OPC_JAL:   begin op = OP_JAL;   sel = IMM_J; wr = 1'b1; end
            OPC_JALR:  begin op = (f3 == 3'b000) ? OP_JALR : OP_ILLEGAL; sel = IMM_I; r1 = 1'b1; wr = 1'b1; end
            OPC_BRANCH: begin
                sel = IMM_B; r1 = 1'b1; r2 = 1'b1;
                case (f3)
                    3'b000: op = OP_BEQ;
                    3'b001: op = OP_BNE;
                    3'b100: op = OP_BLT;
                    3'b101: op = OP_BGE;
                    3'b110: op = OP_BLTU;
                    3'b111: op = OP_BGEU;
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                sel = IMM_I; r1 = 1'b1; wr = 1'b1;
                case (f3)
                    3'b000: op = OP_LB;
                    3'b001: op = OP_LH;
                    3'b010: op = OP_LW;
                    3'b100: op = OP_LBU;
                    3'b101: op = OP_LHU;
                    default: ;
                endcase
            end
            OPC_STORE: begin
                sel = IMM_S; r1 = 1'b1; r2 = 1'b1;
                case (f3)
                    3'b000: op = OP_SB;
                    3'b001: op = OP_SH;
                    3'b010: op = OP_SW;
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                sel = (f3 == 3'b001 || f3 == 3'b101) ? IMM_SHAMT : IMM_I; r1 = 1'b1; wr = 1'b1;
                case (f3)
                    3'b000: op = OP_ADDI;
                    3'b010: op = OP_SLTI;
                    3'b011: op = OP_SLTIU;
                    3'b100: op = OP_XORI;
                    3'b110: op = OP_ORI;
                    3'b111: op = OP_ANDI;
                    3'b001: op = (f7 == 7'b0000000) ? OP_SLLI : OP_ILLEGAL;
                    default: op = (f7 == 7'b0000000) ? OP_SRLI : (f7 == 7'b0100000) ? OP_SRAI : OP_ILLEGAL;
                endcase
            end
            OPC_OP: begin
                r1 = 1'b1; r2 = 1'b1; wr = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000: op = OP_ADD;
                        3'b001: op = OP_SLL;
                        3'b010: op = OP_SLT;
                        3'b011: op = OP_SLTU;
                        3'b100: op = OP_XOR;
                        3'b101: op = OP_SRL;
                        3'b110: op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    op = (f3 == 3'b000) ? OP_SUB : (f3 == 3'b101) ? OP_SRA : OP_ILLEGAL;
                end
`ifdef DECODE_RV32M_EN
                else if (f7 == 7'b0000001) begin
                    op = op_e'(6'(OP_MUL) + 6'(f3));
                end
`endif
            end
            OPC_MISC_MEM: op = (f3 == 3'b000) ? OP_FENCE : OP_ILLEGAL;
            OPC_SYSTEM: begin
                if (instr[31:21] == 11'd0 && instr[19:7] == 13'd0)
                    op = instr[20] ? OP_EBREAK : OP_ECALL;
            end
            default: ;
        endcase
    end
    always_comb begin
        imm = (sel == IMM_I)     ? {{20{instr[31]}}, instr[31:20]} :
              (sel == IMM_S)     ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
              (sel == IMM_B)     ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
              (sel == IMM_U)     ? {instr[31:12], 12'd0} :
              (sel == IMM_J)     ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
              (sel == IMM_SHAMT) ? {27'd0, instr[24:20]} : 32'd0;
        dec.op      = op;
        dec.illegal = (op == OP_ILLEGAL);
        dec.imm     = dec.illegal ? 32'd0 : imm;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];
        dec.rs1_en  = r1 & ~dec.illegal;
        dec.rs2_en  = r2 & ~dec.illegal;
        dec.rd_en   = wr & ~dec.illegal & (instr[11:7] != 5'd0);
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode with output + skid register; DECODE_RV32M_EN passes to decode_comb
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [5:0]      out_op,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rs1_en,
    output logic            out_rs2_en,
    output logic            out_rd_en,
    output logic            out_illegal
);
    state_e state_q, state_d;
    decoded_s dec, out_q, out_d, skid_q, skid_d;
    logic [PC_W-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
    logic in_ready_q, in_ready_d, acc, pop;

    decode_comb u_comb (.instr(in_instr), .dec(dec));

    assign acc = in_valid & in_ready_q;
    assign pop = out_valid & out_ready;
    assign in_ready_d = (state_d != ST_TWO);
    always_comb begin
        state_d = state_q; out_d = out_q; out_pc_d = out_pc_q; skid_d = skid_q; skid_pc_d = skid_pc_q;
        if (flush) state_d = ST_EMPTY;
        else case (state_q)
            ST_EMPTY: if (acc) begin state_d = ST_ONE; out_d = dec; out_pc_d = in_pc; end
            ST_ONE: begin
                if (acc && pop) begin out_d = dec; out_pc_d = in_pc; end
                else if (acc) begin state_d = ST_TWO; skid_d = dec; skid_pc_d = in_pc; end
                else if (pop) state_d = ST_EMPTY;
            end
            ST_TWO: if (pop) begin state_d = ST_ONE; out_d = skid_q; out_pc_d = skid_pc_q; end
            default: state_d = ST_EMPTY;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY; in_ready_q <= 1'b1;
            out_q <= '0; out_pc_q <= '0; skid_q <= '0; skid_pc_q <= '0;
        end else begin
            state_q <= state_d; in_ready_q <= in_ready_d;
            out_q <= out_d; out_pc_q <= out_pc_d; skid_q <= skid_d; skid_pc_q <= skid_pc_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != ST_EMPTY);
    assign out_pc      = out_pc_q;
    assign out_op      = out_q.op;
    assign out_imm     = XLEN'(signed'(out_q.imm));
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_rs1_en  = out_q.rs1_en;
    assign out_rs2_en  = out_q.rs2_en;
    assign out_rd_en   = out_q.rd_en;
    assign out_illegal = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode results, skid back-pressure, flush and reset
module tb_decode_stage;
    import decode_pkg::*;
    localparam int XLEN = 32;
    localparam int PC_W = 32;

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [PC_W-1:0] in_pc = '0;
    logic in_ready, out_valid, out_rs1_en, out_rs2_en, out_rd_en, out_illegal;
    logic [PC_W-1:0] out_pc;
    logic [5:0] out_op;
    logic [XLEN-1:0] out_imm;
    logic [4:0] out_rs1, out_rs2, out_rd;
    int n_vec = 0, n_err = 0;

    decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_op(out_op), .out_imm(out_imm), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd(out_rd), .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en),
        .out_rd_en(out_rd_en), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] instr, input logic [PC_W-1:0] pc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic dec_chk(input string tag, input logic [31:0] instr, input op_e op,
                           input logic [31:0] imm, input logic ill);
        send(instr, 32'h400);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_op"}, 64'(out_op), 64'(op));
        chk({tag, "_imm"}, 64'(out_imm), 64'(imm));
        chk({tag, "_ill"}, 64'(out_illegal), 64'(ill));
        step();
    endtask

    function automatic logic [31:0] addi(input int k);
        return (32'(k) << 20) | 32'h0000_0093;
    endfunction

    initial begin
        step(); step();
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(1));
        chk("rst_op", 64'(out_op), 64'(0));
        chk("rst_imm", 64'(out_imm), 64'(0));
        rst = 1'b0; out_ready = 1'b1;
        step();
        send(32'h0050_0093, 32'h100);
        chk("addi_valid", 64'(out_valid), 64'(1));
        chk("addi_op", 64'(out_op), 64'(OP_ADDI));
        chk("addi_imm", 64'(out_imm), 64'(5));
        chk("addi_rd", 64'(out_rd), 64'(1));
        chk("addi_rd_en", 64'(out_rd_en), 64'(1));
        chk("addi_rs1_en", 64'(out_rs1_en), 64'(1));
        chk("addi_rs2_en", 64'(out_rs2_en), 64'(0));
        chk("addi_ill", 64'(out_illegal), 64'(0));
        chk("addi_pc", 64'(out_pc), 64'(32'h100));
        step();
        chk("drain_valid", 64'(out_valid), 64'(0));
        send(32'hFE00_0EE3, 32'h104);
        chk("beq_op", 64'(out_op), 64'(OP_BEQ));
        chk("beq_imm", 64'(out_imm), 64'(32'hFFFF_FFFC));
        chk("beq_rd_en", 64'(out_rd_en), 64'(0));
        chk("beq_rs2_en", 64'(out_rs2_en), 64'(1));
        step();
        send(32'h0220_81B3, 32'h108);
`ifdef DECODE_RV32M_EN
        chk("mul_op", 64'(out_op), 64'(OP_MUL));
        chk("mul_ill", 64'(out_illegal), 64'(0));
        chk("mul_rs1", 64'(out_rs1), 64'(1));
        chk("mul_rs2", 64'(out_rs2), 64'(2));
        chk("mul_rd", 64'(out_rd), 64'(3));
`else
        chk("mul_op", 64'(out_op), 64'(OP_ILLEGAL));
        chk("mul_ill", 64'(out_illegal), 64'(1));
        chk("mul_rd_en", 64'(out_rd_en), 64'(0));
`endif
        step();
        dec_chk("zero", 32'h0000_0000, OP_ILLEGAL, 32'h0, 1'b1);
        dec_chk("lowbits", 32'h0050_0092, OP_ILLEGAL, 32'h0, 1'b1);
        dec_chk("srai", 32'h4030_D093, OP_SRAI, 32'h3, 1'b0);
        dec_chk("slli_f7", 32'h4030_9093, OP_ILLEGAL, 32'h0, 1'b1);
        dec_chk("lui", 32'h1234_50B7, OP_LUI, 32'h1234_5000, 1'b0);
        dec_chk("ecall", 32'h0000_0073, OP_ECALL, 32'h0, 1'b0);
        dec_chk("ebreak", 32'h0010_0073, OP_EBREAK, 32'h0, 1'b0);
        dec_chk("csrrw", 32'h3000_1073, OP_ILLEGAL, 32'h0, 1'b1);
        dec_chk("fence", 32'h0FF0_000F, OP_FENCE, 32'h0, 1'b0);
        dec_chk("sw", 32'hFE11_2E23, OP_SW, 32'hFFFF_FFFC, 1'b0);
        send(32'h4020_8033, 32'h10C);
        chk("sub_op", 64'(out_op), 64'(OP_SUB));
        chk("sub_rd_en_x0", 64'(out_rd_en), 64'(0));
        step();
        // back-pressure: two entries fit, the third waits for the consumer
        out_ready = 1'b0;
        send(addi(1), 32'h200);
        chk("bp_ready1", 64'(in_ready), 64'(1));
        send(addi(2), 32'h204);
        chk("bp_ready2", 64'(in_ready), 64'(0));
        chk("bp_head", 64'(out_imm), 64'(1));
        in_valid = 1'b1; in_instr = addi(3); in_pc = 32'h208;
        step();
        chk("bp_hold_imm", 64'(out_imm), 64'(1));
        chk("bp_hold_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        step();
        chk("bp_out2", 64'(out_imm), 64'(2));
        chk("bp_out2_pc", 64'(out_pc), 64'(32'h204));
        step();
        chk("bp_out3", 64'(out_imm), 64'(3));
        in_instr = addi(4); in_pc = 32'h20C;
        step();
        in_valid = 1'b0;
        chk("bp_out4", 64'(out_imm), 64'(4));
        step();
        chk("bp_empty", 64'(out_valid), 64'(0));
        // flush in TWO with a concurrent offer
        out_ready = 1'b0;
        send(addi(7), 32'h300);
        send(addi(8), 32'h304);
        in_valid = 1'b1; in_instr = addi(9); flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("fl2_valid", 64'(out_valid), 64'(0));
        chk("fl2_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        step(); step();
        chk("fl2_stays_empty", 64'(out_valid), 64'(0));
        // flush in ONE while an input is accepted
        out_ready = 1'b0;
        send(addi(10), 32'h310);
        in_valid = 1'b1; in_instr = addi(11); flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        chk("fl1_valid", 64'(out_valid), 64'(0));
        step();
        chk("fl1_stays_empty", 64'(out_valid), 64'(0));
        // reset mid-stream
        send(32'h1234_50B7, 32'h500);
        chk("pre_rst_imm", 64'(out_imm), 64'(32'h1234_5000));
        in_valid = 1'b1; in_instr = addi(12); rst = 1'b1;
        step();
        in_valid = 1'b0; rst = 1'b0;
        chk("mrst_valid", 64'(out_valid), 64'(0));
        chk("mrst_ready", 64'(in_ready), 64'(1));
        chk("mrst_imm", 64'(out_imm), 64'(0));
        chk("mrst_pc", 64'(out_pc), 64'(0));
        chk("mrst_rd", 64'(out_rd), 64'(0));
        chk("mrst_op", 64'(out_op), 64'(0));
        chk("mrst_rs1_en", 64'(out_rs1_en), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
